line_fill_buffer: RTL

Collects the wrapping-burst read beats returned by `transfer_handler` (`read_addr`/`read_data`) into one I-cache line and presents the completed line to the cache data/tag array in a single write. It sits directly downstream of `transfer_handler` and upstream of the I-cache array. It forwards the critical (missed) word to the fetch path as soon as that word arrives. One fill is in flight at a time.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/line_fill_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared I-cache definitions.
//   WORDS_PER_LINE / DATA_W / ADDR_W : default line geometry
//   OFF_W / LINE_W                   : word-offset width and line width in bits
//   lfb_state_t                      : line fill buffer FSM states
//   lfb_line_base()                  : clears the byte/word offset bits of an address
package icache_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int LINE_W         = WORDS_PER_LINE * DATA_W;

  typedef enum logic [1:0] {
    LFB_IDLE  = 2'd0,
    LFB_FILL  = 2'd1,
    LFB_WRITE = 2'd2
  } lfb_state_t;

  // Line base: byte offset (2 bits) plus word offset (OFF_W bits) forced to zero.
  function automatic logic [ADDR_W-1:0] lfb_line_base(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = {ADDR_W{1'b1}} << (OFF_W + 2);
    return addr & mask;
  endfunction

endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: gathers one wrapping burst into a full I-cache line.
//   miss_valid/miss_addr/miss_ready : fill request from the fetch path (accepted in IDLE)
//   beat_valid/read_addr/read_data  : returned burst beats
//   crit_valid/crit_data            : one-cycle pulse carrying the missed word
//   fill_valid/fill_ready           : completed line handshake to the array
//   fill_addr/fill_data             : line-aligned address and line data (word i at [i*DATA_W +: DATA_W])
//   busy                            : FSM not in IDLE
module line_fill_buffer #(
  parameter int WORDS_PER_LINE = icache_pkg::WORDS_PER_LINE,
  parameter int DATA_W         = icache_pkg::DATA_W,
  parameter int ADDR_W         = icache_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       miss_valid,
  input  logic [ADDR_W-1:0]          miss_addr,
  output logic                       miss_ready,
  input  logic                       beat_valid,
  input  logic [ADDR_W-1:0]          read_addr,
  input  logic [DATA_W-1:0]          read_data,
  output logic                       crit_valid,
  output logic [DATA_W-1:0]          crit_data,
  output logic                       fill_valid,
  input  logic                       fill_ready,
  output logic [ADDR_W-1:0]          fill_addr,
  output logic [WORDS_PER_LINE*DATA_W-1:0] fill_data,
  output logic                       busy
);

  import icache_pkg::lfb_state_t;
  import icache_pkg::LFB_IDLE;
  import icache_pkg::LFB_FILL;
  import icache_pkg::LFB_WRITE;
  import icache_pkg::lfb_line_base;

  localparam int OFF_W = $clog2(WORDS_PER_LINE);

  lfb_state_t                state_q, state_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [OFF_W-1:0]          crit_off_q, crit_off_d;
  logic [WORDS_PER_LINE-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]         words_q [WORDS_PER_LINE];
  logic [DATA_W-1:0]         words_d [WORDS_PER_LINE];
  logic                      crit_valid_q, crit_valid_d;
  logic [DATA_W-1:0]         crit_data_q, crit_data_d;
  logic                      fill_valid_q, fill_valid_d;

  logic                      beat_hit_s;
  logic [OFF_W-1:0]          beat_slot_s;

  // Beat qualification: only beats of the line being filled, and only in FILL.
  always_comb begin
    beat_slot_s = read_addr[OFF_W+1:2];
    beat_hit_s  = (state_q == LFB_FILL) && beat_valid &&
                  (lfb_line_base(read_addr) == base_q);
  end

  // Next-state, storage update and registered-output next values.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    crit_off_d   = crit_off_q;
    mask_d       = mask_q;
    words_d      = words_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    case (state_q)
      LFB_IDLE: begin
        if (miss_valid) begin
          base_d     = lfb_line_base(miss_addr);
          crit_off_d = miss_addr[OFF_W+1:2];
          mask_d     = '0;
          state_d    = LFB_FILL;
        end else begin
          state_d    = LFB_IDLE;
        end
      end
      LFB_FILL: begin
        if (beat_hit_s) begin
          words_d[beat_slot_s] = read_data;
          mask_d[beat_slot_s]  = 1'b1;
          // Only the first arrival of the missed word is forwarded.
          if ((beat_slot_s == crit_off_q) && !mask_q[beat_slot_s]) begin
            crit_valid_d = 1'b1;
            crit_data_d  = read_data;
          end else begin
            crit_valid_d = 1'b0;
          end
          if (&mask_d) begin
            state_d = LFB_WRITE;
          end else begin
            state_d = LFB_FILL;
          end
        end else begin
          state_d = LFB_FILL;
        end
      end
      LFB_WRITE: begin
        if (fill_valid_q && fill_ready) begin
          state_d = LFB_IDLE;
        end else begin
          state_d = LFB_WRITE;
        end
      end
      default: begin
        state_d = LFB_IDLE;
      end
    endcase
    // fill_valid is a flop that tracks the WRITE state one-for-one.
    fill_valid_d = (state_d == LFB_WRITE);
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= LFB_IDLE;
      base_q       <= '0;
      crit_off_q   <= '0;
      mask_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_valid_q <= 1'b0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      crit_off_q   <= crit_off_d;
      mask_q       <= mask_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      fill_valid_q <= fill_valid_d;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        words_q[i] <= words_d[i];
      end
    end
  end

  // Flatten the word array onto the line bus.
  always_comb begin
    fill_data = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      fill_data[i*DATA_W +: DATA_W] = words_q[i];
    end
  end

  assign miss_ready = (state_q == LFB_IDLE);
  assign busy       = (state_q != LFB_IDLE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = base_q;

endmodule
